// File: rtl/uart_echo_ctrl.sv
// Echo engine between the uart rx-FIFO read side and tx-FIFO write side: byte echo, line echo, or discard.
// Optional statistics counters (rx_count/tx_count) are enabled by defining UART_ECHO_STATS_EN.
module uart_echo_ctrl #(
  parameter int         DBIT   = 8,
  parameter int         DEPTH  = 16,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] TERM   = 8'h0D
`ifdef UART_ECHO_STATS_EN
  ,
  parameter int         CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              rx_empty,
  input  logic [DBIT-1:0]   r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [DBIT-1:0]   w_data,
  output logic              wr_uart,
  input  logic              clr_ovf,
  output logic              busy,
  output logic [ADDR_W:0]   line_len,
  output logic              overflow
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count
`endif
);

  typedef enum logic [2:0] {IDLE, LATCH, SEND, STORE, REPLAY, TERMTX} state_t;

  localparam logic [DBIT-1:0]   TERM_W   = DBIT'(TERM);
  localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t            state, state_n;
  logic [1:0]        mode_q;
  logic [DBIT-1:0]   byte_q;
  logic [ADDR_W-1:0] rd_idx;
  logic [DBIT-1:0]   line_buf [DEPTH];

  logic              is_term, push_ok, last_idx, has_room;
  logic              rd_d, wr_d;
  logic [DBIT-1:0]   w_data_d;

  assign is_term  = (byte_q == TERM_W);
  assign has_room = (line_len < FULL_LEN);
  // Pushes are spaced by a cycle so tx_full has caught up with the previous push.
  assign push_ok  = !tx_full && !wr_uart;
  assign last_idx = (({1'b0, rd_idx} + LEN_ONE) == line_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    // NOTE: default assignment first so every path assigns state_n and no latch is inferred.
    state_n = state;
    unique case (state)
      IDLE:   if (!rx_empty) state_n = LATCH;
      LATCH: begin
        unique case (mode_q)
          2'b00:   state_n = SEND;
          2'b01: begin
            if (is_term) state_n = (line_len != '0) ? REPLAY : TERMTX;
            else         state_n = STORE;
          end
          default: state_n = IDLE;
        endcase
      end
      SEND:   if (!tx_full) state_n = IDLE;
      STORE:  state_n = IDLE;
      REPLAY: if (push_ok && last_idx) state_n = TERMTX;
      TERMTX: if (push_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_d     = (state == IDLE) && !rx_empty;
    wr_d     = 1'b0;
    w_data_d = w_data;
    unique case (state)
      SEND: begin
        wr_d     = !tx_full;
        w_data_d = byte_q;
      end
      REPLAY: begin
        wr_d     = push_ok;
        w_data_d = line_buf[rd_idx];
      end
      TERMTX: begin
        wr_d     = push_ok;
        w_data_d = TERM_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_uart  <= 1'b0;
      wr_uart  <= 1'b0;
      w_data   <= '0;
      busy     <= 1'b0;
      line_len <= '0;
      overflow <= 1'b0;
      mode_q   <= 2'b00;
      byte_q   <= '0;
      rd_idx   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rd_uart <= rd_d;
      wr_uart <= wr_d;
      w_data  <= w_data_d;
      busy    <= (state_n != IDLE);
      if (clr_ovf) overflow <= 1'b0;
      unique case (state)
        IDLE: begin
          mode_q <= mode;
          // Leaving line mode abandons whatever was buffered.
          if (mode != 2'b01) line_len <= '0;
          if (!rx_empty) byte_q <= r_data;
        end
        LATCH:  if (mode_q == 2'b01 && is_term) rd_idx <= '0;
        STORE: begin
          if (has_room) line_len <= line_len + LEN_ONE;
          else          overflow <= 1'b1;
        end
        REPLAY: if (push_ok) rd_idx <= rd_idx + IDX_ONE;
        TERMTX: if (push_ok) line_len <= '0;
        default: ;
      endcase
    end
  end

  // NOTE: the line buffer has no reset; it is only read below line_len, which does reset.
  always_ff @(posedge clk) begin
    if (state == STORE && has_room) line_buf[line_len[ADDR_W-1:0]] <= byte_q;
  end

`ifdef UART_ECHO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= '0;
      tx_count <= '0;
    end else if (clr_ovf) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (rd_uart && rx_count != '1) rx_count <= rx_count + CNT_W'(1);
      if (wr_uart && tx_count != '1) tx_count <= tx_count + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
